// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_ctrl_pkg                                                      |
// | Brief   : Link-wide widths, command codes and device states.                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package mem_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int RA_W   = 4;
    localparam int CA_W   = 12;
    localparam int CNT_W  = $clog2(DATA_W);

    typedef enum logic [2:0] {
        CMD_NOP = 3'b000,
        CMD_ACT = 3'b001,
        CMD_RD  = 3'b010,
        CMD_WR  = 3'b011,
        CMD_PRE = 3'b100,
        CMD_REF = 3'b101
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACTIVE   = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RD_BURST = 3'd3,
        ST_WR_WAIT  = 3'd4,
        ST_WR_BURST = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_dev_serdes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_dev_serdes                                                    |
// | Brief   : Word shift register, bit counter and DQ tri-state driver.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_dev_serdes
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_drive_start,
    input  logic              i_capture,
    output logic              o_last,
    output logic [DATA_W-1:0] o_word_in,
    inout  wire               io_dq
);

    logic [DATA_W-1:0] r_sr;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_oe;

    // Output enable is reset asynchronously so DQ is released the moment rst_n falls.
    assign io_dq     = r_oe ? r_sr[DATA_W-1] : 1'bz;
    assign o_last    = (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign o_word_in = {r_sr[DATA_W-2:0], io_dq};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_oe      <= 1'b0;
        end else begin
            if (i_load) begin
                r_sr <= i_load_data;
            end else if (r_oe) begin
                r_sr <= {r_sr[DATA_W-2:0], 1'b0};
            end else if (i_capture) begin
                r_sr <= o_word_in;
            end

            // Counter wraps back to zero on the edge that ends a burst.
            if (r_oe || i_capture) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end

            if (i_drive_start) begin
                r_oe <= 1'b1;
            end else if (r_oe && o_last) begin
                r_oe <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_dev_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_dev_responder                                                 |
// | Brief   : Memory-device side of the link: command FSM plus word array.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_dev_responder
    import mem_ctrl_pkg::*;
#(
    parameter int COL_USE = 4,
    parameter int RD_LAT  = 2,
    parameter int WR_LAT  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cs_n,
    input  logic [2:0]      command,
    input  logic [RA_W-1:0] RA,
    input  logic [CA_W-1:0] CA,
    inout  wire             DQ,
    output logic            busy,
    output logic            row_open,
    output logic            err
);

    localparam int c_LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int c_LAT_W   = $clog2(c_LAT_MAX) + 1;
    localparam int c_IDX_W   = RA_W + COL_USE;
    localparam int c_DEPTH   = 1 << c_IDX_W;

    state_e               r_state;
    logic [RA_W-1:0]      r_row;
    logic [COL_USE-1:0]   r_col;
    logic [c_LAT_W-1:0]   r_lat;
    logic                 r_busy;
    logic                 r_row_open;
    logic                 r_err;
    logic [DATA_W-1:0]    r_mem [c_DEPTH];

    logic                 w_cmd_valid;
    logic                 w_rd_accept;
    logic                 w_drive_start;
    logic                 w_capture;
    logic                 w_last;
    logic                 w_wr_done;
    logic [c_IDX_W-1:0]   w_rd_idx;
    logic [DATA_W-1:0]    w_word_in;

    assign w_cmd_valid   = !cs_n && (command != CMD_NOP);
    assign w_rd_accept   = (r_state == ST_ACTIVE) && w_cmd_valid && (command == CMD_RD);
    assign w_drive_start = (r_state == ST_RD_WAIT) && (r_lat == '0);
    assign w_capture     = ((r_state == ST_WR_WAIT) && (r_lat == '0)) || (r_state == ST_WR_BURST);
    assign w_wr_done     = (r_state == ST_WR_BURST) && w_last;
    assign w_rd_idx      = {r_row, CA[COL_USE-1:0]};

    // Upper column bits deliberately alias onto the same array entries.
    generate
        if (COL_USE < CA_W) begin : g_ca_unused
            logic w_unused_ca;
            assign w_unused_ca = ^CA[CA_W-1:COL_USE];
        end
    endgenerate

    assign busy     = r_busy;
    assign row_open = r_row_open;
    assign err      = r_err;

    mem_dev_serdes u_serdes (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_rd_accept),
        .i_load_data   (r_mem[w_rd_idx]),
        .i_drive_start (w_drive_start),
        .i_capture     (w_capture),
        .o_last        (w_last),
        .o_word_in     (w_word_in),
        .io_dq         (DQ)
    );

    // Storage has no reset so its contents survive a device reset.
    always_ff @(posedge clk) begin
        if (w_wr_done) begin
            r_mem[{r_row, r_col}] <= w_word_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_lat      <= '0;
            r_busy     <= 1'b0;
            r_row_open <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_valid) begin
                        case (command)
                            CMD_ACT: begin
                                r_row      <= RA;
                                r_row_open <= 1'b1;
                                r_state    <= ST_ACTIVE;
                            end
                            CMD_REF: ;
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                ST_ACTIVE: begin
                    if (w_cmd_valid) begin
                        case (command)
                            CMD_RD: begin
                                r_col   <= CA[COL_USE-1:0];
                                r_lat   <= c_LAT_W'(RD_LAT - 1);
                                r_busy  <= 1'b1;
                                r_state <= ST_RD_WAIT;
                            end
                            CMD_WR: begin
                                r_col   <= CA[COL_USE-1:0];
                                r_lat   <= c_LAT_W'(WR_LAT - 1);
                                r_busy  <= 1'b1;
                                r_state <= ST_WR_WAIT;
                            end
                            CMD_PRE: begin
                                r_row_open <= 1'b0;
                                r_state    <= ST_IDLE;
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                ST_RD_WAIT, ST_WR_WAIT: begin
                    r_err <= w_cmd_valid;
                    if (r_lat == '0) begin
                        r_state <= (r_state == ST_RD_WAIT) ? ST_RD_BURST : ST_WR_BURST;
                    end else begin
                        r_lat <= r_lat - c_LAT_W'(1);
                    end
                end
                ST_RD_BURST, ST_WR_BURST: begin
                    r_err <= w_cmd_valid;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_ACTIVE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
